// File: rtl/evu_event_arbiter.sv
// evu_event_arbiter: per-lane saturating event counters drained round-robin
// into one valid/ready record channel {lane, count, info} toward the SPU.
//
// Ports:
//   clk_i, rst_i       clock; synchronous active-high reset
//   event_i            per-lane event strobe
//   info_i             side info latched with every counted event
//   lane_en_i          per-lane count enable
//   flush_i            drop pending counts and the held record
//   clr_ovf_i          clear sticky overflow flags
//   out_valid_o        record valid; out_ready_i accepts it
//   out_lane_o         granted lane
//   out_count_o        events accumulated for that lane
//   out_info_o         info from that lane's latest counted event
//   overflow_o         sticky per-lane saturation loss flag
//   out_ts_o           grant-time cycle stamp (EVU_ARB_TIMESTAMP_EN only)
//
// Optional feature macro: EVU_ARB_TIMESTAMP_EN
module evu_event_arbiter #(
   parameter int NUM_LANES = 4,
   parameter int CNT_W     = 8,
   parameter int INFO_W    = 18
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [NUM_LANES-1:0]         event_i,
   input  logic [INFO_W-1:0]            info_i,
   input  logic [NUM_LANES-1:0]         lane_en_i,
   input  logic                         flush_i,
   input  logic                         clr_ovf_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [$clog2(NUM_LANES)-1:0] out_lane_o,
   output logic [CNT_W-1:0]             out_count_o,
   output logic [INFO_W-1:0]            out_info_o,
`ifdef EVU_ARB_TIMESTAMP_EN
   output logic [31:0]                  out_ts_o,
`endif
   output logic [NUM_LANES-1:0]         overflow_o
);

   localparam int LW = $clog2(NUM_LANES);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef logic [LW-1:0] lane_t;

   logic [CNT_W-1:0]     cnt  [NUM_LANES];
   logic [INFO_W-1:0]    info [NUM_LANES];
   lane_t                rr_ptr;

   logic [NUM_LANES-1:0] ev;
   logic [NUM_LANES-1:0] nz;
   logic [NUM_LANES-1:0] sat;
   logic                 slot_free;
   logic                 gnt_any;
   logic                 grant;
   lane_t                gnt_lane;
   lane_t                nxt_ptr;
   lane_t                sel;
   int                   idx;

   always_comb begin
      ev        = '0;
      nz        = '0;
      sat       = '0;
      gnt_any   = 1'b0;
      gnt_lane  = '0;
      sel       = '0;
      idx       = 0;
      for (int k = 0; k < NUM_LANES; k++) begin
         ev[k] = event_i[k] & lane_en_i[k];
         nz[k] = (cnt[k] != '0);
      end
      // first non-empty lane at or after rr_ptr, wrapping
      for (int i = 0; i < NUM_LANES; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NUM_LANES)
            idx = idx - NUM_LANES;
         sel = lane_t'(idx);
         if (!gnt_any && nz[sel]) begin
            gnt_any  = 1'b1;
            gnt_lane = sel;
         end
      end
      slot_free = ~out_valid_o | out_ready_i;
      grant     = slot_free & gnt_any & ~flush_i;
      if (gnt_lane == lane_t'(NUM_LANES - 1))
         nxt_ptr = '0;
      else
         nxt_ptr = gnt_lane + lane_t'(1);
      // a granted lane restarts from zero, so its event is never lost
      for (int k = 0; k < NUM_LANES; k++) begin
         sat[k] = ev[k] & ~flush_i & (cnt[k] == CNT_MAX)
                & ~(grant & (gnt_lane == lane_t'(k)));
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < NUM_LANES; k++) begin
            cnt[k]  <= '0;
            info[k] <= '0;
         end
         rr_ptr      <= '0;
         out_valid_o <= 1'b0;
         out_lane_o  <= '0;
         out_count_o <= '0;
         out_info_o  <= '0;
         overflow_o  <= '0;
      end else begin
         // set beats clear when both land in one cycle
         overflow_o <= (overflow_o & ~{NUM_LANES{clr_ovf_i}}) | sat;
         for (int k = 0; k < NUM_LANES; k++) begin
            if (flush_i)
               cnt[k] <= '0;
            else if (grant && (gnt_lane == lane_t'(k)))
               cnt[k] <= {{(CNT_W-1){1'b0}}, ev[k]};
            else if (ev[k] && (cnt[k] != CNT_MAX))
               cnt[k] <= cnt[k] + 1'b1;
            if (ev[k] && !flush_i)
               info[k] <= info_i;
         end
         if (flush_i) begin
            out_valid_o <= 1'b0;
         end else if (grant) begin
            out_valid_o <= 1'b1;
            out_lane_o  <= gnt_lane;
            out_count_o <= cnt[gnt_lane];
            out_info_o  <= info[gnt_lane];
            rr_ptr      <= nxt_ptr;
         end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
         end
      end
   end

`ifdef EVU_ARB_TIMESTAMP_EN
   logic [31:0] ts;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ts       <= '0;
         out_ts_o <= '0;
      end else begin
         ts <= ts + 32'd1;
         if (grant)
            out_ts_o <= ts;
      end
   end
`endif

endmodule
